bond_ifc_n: RTL

Parametrised N-channel bonding bridge. Presents one wide Avalon-MM slave of NCH*CH_DW bits and fans each command out to NCH narrow DDR Avalon-MM masters. Tracks per-channel command acceptance, so channels with skewed waitrequest are each issued exactly once. Realigns skewed read responses through per-channel response queues, gated by read credits. Sits between the wide video/DMA interconnect and the DDR controllers.

---
 rtl/bond_ifc_pkg.sv | 13 +
 rtl/bond_rdq.sv | 49 ++++
 rtl/bond_ifc_n.sv | 113 +++++++++++
 3 files changed

// File: rtl/bond_ifc_pkg.sv
// Shared helpers for the channel-bonding bridge: credit counter sizing and
// positional slice offsets used to carve wide buses into per-channel lanes.
package bond_ifc_pkg;

  function automatic int credit_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/bond_rdq.sv
// Per-channel show-ahead read-beat queue: head valid the cycle after push, no bubble on pop.
// Backpressure: a push while full is dropped and reported via full; pop while empty is ignored.
module bond_rdq #(
  parameter int DW    = 64,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] head_dat,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic          push_ok, pop_ok;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_dat = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + (PW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (PW+1)'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[PW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/bond_ifc_n.sv
// Wide Avalon-MM slave bonded onto NCH narrow DDR masters; read beats realigned, 2-cycle latency.
// Backpressure: waitrequest until every channel has taken the command; reads also wait for queue credit.
module bond_ifc_n
  import bond_ifc_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int CH_DW     = 64,
  parameter int AW        = 26,
  parameter int BCW       = 4,
  parameter int RDQ_DEPTH = 16
) (
  input  logic                     csi_clk,
  input  logic                     rsi_reset_n,
  input  logic [AW-1:0]            avs_slave_address,
  input  logic [NCH*CH_DW/8-1:0]   avs_slave_byteenable,
  input  logic                     avs_slave_read,
  input  logic                     avs_slave_write,
  input  logic [NCH*CH_DW-1:0]     avs_slave_writedata,
  input  logic [BCW-1:0]           avs_slave_burstcount,
  input  logic                     avs_slave_beginbursttransfer,
  output logic                     avs_slave_waitrequest,
  output logic [NCH*CH_DW-1:0]     avs_slave_readdata,
  output logic                     avs_slave_readdatavalid,
  output logic [NCH*AW-1:0]        avm_ddr_address,
  output logic [NCH*CH_DW/8-1:0]   avm_ddr_byteenable,
  output logic [NCH-1:0]           avm_ddr_read,
  output logic [NCH-1:0]           avm_ddr_write,
  output logic [NCH*CH_DW-1:0]     avm_ddr_writedata,
  output logic [NCH*BCW-1:0]       avm_ddr_burstcount,
  output logic [NCH-1:0]           avm_ddr_beginbursttransfer,
  input  logic [NCH-1:0]           avm_ddr_waitrequest,
  input  logic [NCH*CH_DW-1:0]     avm_ddr_readdata,
  input  logic [NCH-1:0]           avm_ddr_readdatavalid,
  output logic                     err_overflow
);
  localparam int CW = credit_w(RDQ_DEPTH);
  localparam int SW = ((CW > BCW) ? CW : BCW) + 1;

  logic [NCH-1:0]       done_q, done_d;
  logic [CW-1:0]        outst_q, outst_d;
  logic                 rd_vld_q, rd_vld_d;
  logic [NCH*CH_DW-1:0] rd_dat_q, rd_dat_d;
  logic                 err_q, err_d;

  logic                 cmd, rd_cmd, withhold, all_done, commit, pop;
  logic [SW-1:0]        credit_need;
  logic [NCH-1:0]       issue, accept_now, q_full, q_empty;
  logic [NCH*CH_DW-1:0] q_head;

  always_comb begin
    cmd         = avs_slave_read | avs_slave_write;
    rd_cmd      = avs_slave_read & ~avs_slave_write;
    credit_need = SW'(outst_q) + SW'(avs_slave_burstcount);
    // Credit is only checked before the first channel takes the read; after
    // that the stragglers must follow regardless.
    withhold    = rd_cmd & ~(|done_q) & (credit_need > SW'(RDQ_DEPTH));
    issue       = (cmd && !withhold && rsi_reset_n) ? ~done_q : '0;
    accept_now  = issue & ~avm_ddr_waitrequest;
    all_done    = &(done_q | accept_now);
    done_d      = all_done ? '0 : (done_q | accept_now);
    commit      = rd_cmd & ~(|done_q) & (|accept_now);
    pop         = &(~q_empty);
    outst_d     = outst_q + (commit ? CW'(avs_slave_burstcount) : '0) - CW'(pop);
    rd_vld_d    = pop;
    rd_dat_d    = pop ? q_head : rd_dat_q;
    err_d       = err_q | (|(avm_ddr_readdatavalid & q_full));
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      done_q   <= '0;
      outst_q  <= '0;
      rd_vld_q <= 1'b0;
      rd_dat_q <= '0;
      err_q    <= 1'b0;
    end else begin
      done_q   <= done_d;
      outst_q  <= outst_d;
      rd_vld_q <= rd_vld_d;
      rd_dat_q <= rd_dat_d;
      err_q    <= err_d;
    end
  end

  assign avs_slave_waitrequest      = ~all_done;
  assign avs_slave_readdata         = rd_dat_q;
  assign avs_slave_readdatavalid    = rd_vld_q;
  assign err_overflow               = err_q;
  assign avm_ddr_read               = issue & {NCH{rd_cmd}};
  assign avm_ddr_write              = issue & {NCH{avs_slave_write}};
  assign avm_ddr_beginbursttransfer = issue & {NCH{avs_slave_beginbursttransfer}};
  assign avm_ddr_byteenable         = avs_slave_byteenable;
  assign avm_ddr_writedata          = avs_slave_writedata;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam int DLO = slice_lo(i, CH_DW);

    assign avm_ddr_address[slice_lo(i, AW) +: AW]     = avs_slave_address;
    assign avm_ddr_burstcount[slice_lo(i, BCW) +: BCW] = avs_slave_burstcount;

    bond_rdq #(.DW(CH_DW), .DEPTH(RDQ_DEPTH)) u_rdq (
      .clk      (csi_clk),
      .rst_n    (rsi_reset_n),
      .push     (avm_ddr_readdatavalid[i]),
      .push_dat (avm_ddr_readdata[DLO +: CH_DW]),
      .pop      (pop),
      .head_dat (q_head[DLO +: CH_DW]),
      .full     (q_full[i]),
      .empty    (q_empty[i])
    );
  end

endmodule
